// File: rtl/decode_imm_stage_pkg.sv
// decode_imm_stage_pkg: immediate-type encodings, opcode constants and buffer entry layout.
// The illegal flag in entry_t exists only when DECODE_ILLEGAL_CHECK_EN is defined.
package decode_imm_stage_pkg;

  typedef enum logic [2:0] {
    IMM_NO = 3'd0,
    IMM_U  = 3'd1,
    IMM_J  = 3'd2,
    IMM_I  = 3'd3,
    IMM_B  = 3'd4,
    IMM_S  = 3'd5
  } imm_type_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    imm_type_e   imm_type;
`ifdef DECODE_ILLEGAL_CHECK_EN
    logic        illegal;
`endif
  } entry_t;

endpackage

// File: rtl/decode_imm_stage_imm_gen.sv
// imm_gen: purely combinational RISC-V immediate formation for a given immediate type.
// Opcode bits are not needed here, so only instr[31:7] enters.
module imm_gen
  import decode_imm_stage_pkg::*;
(
  input  logic [31:7] instr,
  input  imm_type_e   imm_type,
  output logic [31:0] imm
);

  always_comb begin
    imm = imm_type == IMM_U ? {instr[31:12], 12'h0} :
          imm_type == IMM_J ? {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0} :
          imm_type == IMM_I ? {{20{instr[31]}}, instr[31:20]} :
          imm_type == IMM_B ? {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0} :
          imm_type == IMM_S ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
          32'h0;
  end

endmodule

// File: rtl/decode_imm_stage.sv
// decode_imm_stage: decode stage with output + skid buffer, registering the immediate per entry.
// Optional illegal-opcode flag compiled in with DECODE_ILLEGAL_CHECK_EN.
module decode_imm_stage
  import decode_imm_stage_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        flush_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_instr_o,
  output logic [31:0] out_pc_o,
  output logic [31:0] imm_o,
  output logic [2:0]  immType_o
`ifdef DECODE_ILLEGAL_CHECK_EN
  , output logic      illegal_o
`endif
);

  state_e      state_q, state_d;
  entry_t      in_e, out_q, skid_q;
  imm_type_e   in_type;
  logic [31:0] in_imm;
  logic [6:0]  opc;
  logic        accept, pop, load_out, load_skid;

  assign opc = instr_i[6:0];

  always_comb begin
    in_type = (opc == OPC_LUI || opc == OPC_AUIPC) ? IMM_U :
              opc == OPC_JAL ? IMM_J :
              (opc == OPC_OP_IMM || opc == OPC_LOAD || opc == OPC_JALR || opc == OPC_SYSTEM) ? IMM_I :
              opc == OPC_BRANCH ? IMM_B :
              opc == OPC_STORE ? IMM_S :
              IMM_NO;
  end

  imm_gen u_imm_gen (
    .instr    (instr_i[31:7]),
    .imm_type (in_type),
    .imm      (in_imm)
  );

  always_comb begin
    in_e          = '0;
    in_e.instr    = instr_i;
    in_e.pc       = pc_i;
    in_e.imm      = in_imm;
    in_e.imm_type = in_type;
`ifdef DECODE_ILLEGAL_CHECK_EN
    in_e.illegal  = in_type == IMM_NO && opc != OPC_OP;
`endif
  end

  assign accept = in_valid_i && in_ready_o;
  assign pop    = out_valid_o && out_ready_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_EMPTY;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) state_d = ST_EMPTY;
    else if (state_q == ST_EMPTY) state_d = accept ? ST_ONE : ST_EMPTY;
    else if (state_q == ST_ONE) state_d = (accept && !pop) ? ST_TWO : (!accept && pop) ? ST_EMPTY : ST_ONE;
    else if (state_q == ST_TWO) state_d = pop ? ST_ONE : ST_TWO;
  end

  // Both handshake flags decode only the state register, keeping out_ready_i off the in_ready_o path.
  always_comb begin
    in_ready_o  = state_q != ST_TWO;
    out_valid_o = state_q != ST_EMPTY;
  end

  assign load_out  = (accept && (state_q == ST_EMPTY || pop)) || (state_q == ST_TWO && pop);
  assign load_skid = state_q == ST_ONE && accept && !pop;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_q  <= '0;
      skid_q <= '0;
    end else if (!flush_i) begin
      if (load_out)  out_q  <= state_q == ST_TWO ? skid_q : in_e;
      if (load_skid) skid_q <= in_e;
    end
  end

  assign out_instr_o = out_q.instr;
  assign out_pc_o    = out_q.pc;
  assign imm_o       = out_q.imm;
  assign immType_o   = out_q.imm_type;
`ifdef DECODE_ILLEGAL_CHECK_EN
  assign illegal_o   = out_q.illegal;
`endif

endmodule

// File: tb/tb_decode_imm_stage.sv
// tb_decode_imm_stage: directed self-checking bench for decode_imm_stage.
// Inputs change and outputs are sampled on the falling edge; DUT state moves on the rising edge.
module tb_decode_imm_stage;

  logic        clk = 1'b0;
  logic        rst_n_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        out_ready_i = 1'b0;
  logic [31:0] instr_i = '0;
  logic [31:0] pc_i = '0;
  logic        in_ready_o, out_valid_o;
  logic [31:0] out_instr_o, out_pc_o, imm_o;
  logic [2:0]  imm_type;
`ifdef DECODE_ILLEGAL_CHECK_EN
  logic        illegal_o;
`endif

  int checks = 0;
  int failures = 0;

  localparam int N = 11;
  logic [31:0] v_instr [N] = '{32'h12345037, 32'hFE000EE3, 32'h0020A423, 32'h0000006F,
                              32'h00001097, 32'hFFDFF0EF, 32'hFE112E23, 32'h0000A083,
                              32'h002081B3, 32'hFFF00067, 32'h00208463};
  logic [31:0] v_imm   [N] = '{32'h12345000, 32'hFFFFFFFC, 32'h00000008, 32'h00000000,
                              32'h00001000, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h00000000,
                              32'h00000000, 32'hFFFFFFFF, 32'h00000008};
  logic [2:0]  v_type  [N] = '{3'd1, 3'd4, 3'd5, 3'd2, 3'd1, 3'd2, 3'd5, 3'd3, 3'd0, 3'd3, 3'd4};

  always #5 clk = ~clk;

  decode_imm_stage dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .instr_i     (instr_i),
    .pc_i        (pc_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_instr_o (out_instr_o),
    .out_pc_o    (out_pc_o),
    .imm_o       (imm_o),
    .immType_o   (imm_type)
`ifdef DECODE_ILLEGAL_CHECK_EN
    , .illegal_o (illegal_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    in_valid_i = v;
    instr_i = ins;
    pc_i = pc;
  endtask

  initial begin
    #1 rst_n_i = 1'b0;
    #2;
    chk("rst_valid", out_valid_o, 0);
    chk("rst_ready", in_ready_o, 1);
    chk("rst_instr", out_instr_o, 0);
    chk("rst_pc", out_pc_o, 0);
    chk("rst_imm", imm_o, 0);
    chk("rst_type", imm_type, 0);
    @(negedge clk);
    rst_n_i = 1'b1;
    out_ready_i = 1'b1;
    drive(1, 32'hFFF00093, 32'h100);
    @(negedge clk);
    drive(0, 0, 0);
    chk("addi_valid", out_valid_o, 1);
    chk("addi_type", imm_type, 3);
    chk("addi_imm", imm_o, 32'hFFFFFFFF);
    chk("addi_instr", out_instr_o, 32'hFFF00093);
    chk("addi_pc", out_pc_o, 32'h100);
    @(negedge clk);
    chk("addi_drained", out_valid_o, 0);
    for (int i = 0; i <= N; i++) begin
      if (i > 0) begin
        chk("seq_valid", out_valid_o, 1);
        chk("seq_ready", in_ready_o, 1);
        chk("seq_instr", out_instr_o, v_instr[i-1]);
        chk("seq_pc", out_pc_o, 32'h1000 + 4 * (i - 1));
        chk("seq_imm", imm_o, v_imm[i-1]);
        chk("seq_type", imm_type, {29'h0, v_type[i-1]});
      end
      if (i < N) drive(1, v_instr[i], 32'h1000 + 4 * i);
      else drive(0, 0, 0);
      @(negedge clk);
    end
    chk("seq_drained", out_valid_o, 0);
    out_ready_i = 1'b0;
    drive(1, 32'h00500093, 32'h200);
    @(negedge clk);
    chk("bp_one_valid", out_valid_o, 1);
    chk("bp_one_ready", in_ready_o, 1);
    drive(1, 32'hFFB00113, 32'h204);
    @(negedge clk);
    chk("bp_two_ready", in_ready_o, 0);
    chk("bp_two_instr", out_instr_o, 32'h00500093);
    drive(1, 32'h00700193, 32'h208);
    @(negedge clk);
    chk("bp_hold_instr", out_instr_o, 32'h00500093);
    chk("bp_hold_imm", imm_o, 32'h5);
    chk("bp_hold_ready", in_ready_o, 0);
    drive(0, 0, 0);
    out_ready_i = 1'b1;
    @(negedge clk);
    chk("bp_second_valid", out_valid_o, 1);
    chk("bp_second_instr", out_instr_o, 32'hFFB00113);
    chk("bp_second_pc", out_pc_o, 32'h204);
    chk("bp_second_imm", imm_o, 32'hFFFFFFFB);
    chk("bp_second_ready", in_ready_o, 1);
    @(negedge clk);
    chk("bp_no_dup", out_valid_o, 0);
    out_ready_i = 1'b0;
    drive(1, 32'h00100093, 32'h300);
    @(negedge clk);
    drive(1, 32'h00200093, 32'h304);
    @(negedge clk);
    chk("fl_two_ready", in_ready_o, 0);
    flush_i = 1'b1;
    drive(1, 32'h00300093, 32'h308);
    @(negedge clk);
    flush_i = 1'b0;
    drive(0, 0, 0);
    chk("fl_valid", out_valid_o, 0);
    chk("fl_ready", in_ready_o, 1);
    out_ready_i = 1'b1;
    @(negedge clk);
    chk("fl_dropped", out_valid_o, 0);
    drive(1, 32'h06400093, 32'h400);
    @(negedge clk);
    drive(0, 0, 0);
    chk("fl_after_instr", out_instr_o, 32'h06400093);
    chk("fl_after_imm", imm_o, 32'h64);
    @(negedge clk);
    out_ready_i = 1'b0;
    drive(1, 32'hFFF00093, 32'h500);
    @(negedge clk);
    drive(0, 0, 0);
    chk("ar_pre_valid", out_valid_o, 1);
    #2 rst_n_i = 1'b0;
    #1;
    chk("ar_valid", out_valid_o, 0);
    chk("ar_imm", imm_o, 0);
    chk("ar_type", imm_type, 0);
    chk("ar_ready", in_ready_o, 1);
    chk("ar_instr", out_instr_o, 0);
    @(negedge clk);
    rst_n_i = 1'b1;
    @(negedge clk);
    chk("ar_after_valid", out_valid_o, 0);
`ifdef DECODE_ILLEGAL_CHECK_EN
    out_ready_i = 1'b1;
    drive(1, 32'h0000007F, 32'h600);
    @(negedge clk);
    drive(1, 32'hFFF00093, 32'h604);
    chk("ill_flag", illegal_o, 1);
    chk("ill_type", imm_type, 0);
    chk("ill_imm", imm_o, 0);
    @(negedge clk);
    drive(0, 0, 0);
    chk("ill_clear", illegal_o, 0);
    chk("ill_next_type", imm_type, 3);
    @(negedge clk);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_imm_stage.md
DECODE_IMM_STAGE -- requirements
Module: decode_imm_stage

Interface
REQ-001 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n_i, input, 1, the reset; asynchronous, active-low.
REQ-003 SHALL have port flush_i, input, 1, pipeline flush (branch/interrupt redirect).
REQ-004 SHALL have ports in_valid_i (input, 1) and in_ready_o (output, 1), the upstream (fetch) handshake.
REQ-005 SHALL have ports instr_i (input, 32) and pc_i (input, 32), the fetched instruction and its address.
REQ-006 SHALL have ports out_valid_o (output, 1) and out_ready_i (input, 1), the downstream (execute) handshake.
REQ-007 SHALL have ports out_instr_o (output, 32) and out_pc_o (output, 32), the instruction and PC held in the output entry.
REQ-008 SHALL have ports imm_o (output, 32) and immType_o (output, 3), the extended immediate and its type.
REQ-009 SHALL have port illegal_o, output, 1, unrecognised opcode flag; exists only per REQ-024.

Function
REQ-010 SHALL transfer on the input side when in_valid_i && in_ready_o, and on the output side when out_valid_o && out_ready_i.
REQ-011 SHALL hold an output entry (OUT) and one skid entry (SKID); states EMPTY, ONE (OUT full), TWO (OUT+SKID full).
REQ-012 SHALL make transitions as follows.
- EMPTY + accept -> ONE.
- ONE + accept without pop -> TWO.
- ONE + pop without accept -> EMPTY.
- ONE + accept + pop -> ONE.
- TWO + pop -> ONE, with SKID moved into OUT.
REQ-013 SHALL drive in_ready_o = (state != TWO) from a register, with no combinational path from out_ready_i.
REQ-014 SHALL give a latency of 1 cycle: an instruction accepted at edge N is presented with out_valid_o=1 after edge N.
REQ-015 SHALL decode opcode instr_i[6:0] to an immediate type at accept time.
- LUI 0110111, AUIPC 0010111 -> U.
- JAL 1101111 -> J.
- OP_IMM 0010011, LOAD 0000011, JALR 1100111, SYSTEM 1110011 -> I.
- BRANCH 1100011 -> B.
- STORE 0100011 -> S.
- OP 0110011 and all others -> NO.
REQ-016 SHALL form the immediates as follows.
- U = {instr[31:12],12'h0}.
- J = sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
- I = sext(instr[31:20]).
- B = sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
- S = sext({instr[31:25],instr[11:7]}).
- NO = 0.
REQ-017 SHALL register imm_o and immType_o with each entry, so there is no combinational path from instr_i to imm_o.
REQ-018 SHALL keep outputs stable while out_valid_o && !out_ready_i.
REQ-019 SHALL, on flush_i=1, empty both entries at the next edge and drop any instruction offered in the flush cycle; in_ready_o=1 the following cycle; flush has priority over accept and pop.
REQ-020 SHALL preserve FIFO order across the skid path.

Reset
REQ-021 SHALL, while rst_n_i=0, asynchronously force state EMPTY.
- out_valid_o=0, in_ready_o=1.
- out_instr_o, out_pc_o, imm_o = 32'h0.
- immType_o = IMM_NO, illegal_o = 0.
REQ-022 SHALL discard in-flight entries on reset mid-transfer; no output handshake completes in the reset cycle.
REQ-023 SHALL deassert reset synchronously to clk_i at the system level; the block needs no internal synchroniser.

Configuration
REQ-024 SHALL have illegal-opcode checking compiled in only when DECODE_ILLEGAL_CHECK_EN is defined.
- Defined: illegal_o exists and is registered with the entry, 1 when the opcode matches none of the REQ-015 list.
- Undefined: illegal_o is absent and unrecognised opcodes pass silently as type NO.

Structure
REQ-025 SHALL place the immType encodings (IMM_NO, IMM_U, IMM_J, IMM_I, IMM_B, IMM_S) and the opcode constants in the shared definitions header.
REQ-026 SHALL implement immediate formation in one combinational sub-module, imm_gen, instantiated once on the input path.
REQ-027 SHALL keep the buffer state machine and the decode-to-type logic in decode_imm_stage.

Verification
REQ-028 SHALL cover: push 0xFFF00093 (ADDI -1), out_ready_i=1 -> one cycle later out_valid_o=1, immType_o=IMM_I, imm_o=0xFFFFFFFF.
REQ-029 SHALL cover: push 0x12345037, 0xFE000EE3, 0x0020A423, 0x0000006F back-to-back -> imm_o 0x12345000 (U), 0xFFFFFFFC (B), 0x00000008 (S), 0x00000000 (J), in order.
REQ-030 SHALL cover: out_ready_i=0, push two instructions -> in_ready_o=0 after the second; raise out_ready_i -> both emitted in order, no loss or duplicate.
REQ-031 SHALL cover: state TWO, assert flush_i with in_valid_i=1 -> next cycle out_valid_o=0, in_ready_o=1, and the offered instruction never appears.
REQ-032 SHALL cover: pull rst_n_i low mid-stream, asynchronously between edges -> out_valid_o=0 and imm_o=0 immediately, without waiting for a clock edge.
REQ-033 SHALL cover, with DECODE_ILLEGAL_CHECK_EN defined: push 0x0000007F -> illegal_o=1, immType_o=IMM_NO, imm_o=0.
